// File: rtl/prbs_pkg.sv
// Shared PRBS7 definitions (x^7+x^6+1, XNOR feedback) for the generator and checker.
// Both sides use the same feedback function, so they always agree on the sequence.
package prbs_pkg;
    localparam int PRBS7_W = 7;
    localparam int TAP_HI = 6;
    localparam int TAP_LO = 5;
    localparam logic [PRBS7_W-1:0] LOCKUP_STATE = 7'h7F;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    function automatic logic prbs7_fb(input logic [PRBS7_W-1:0] s);
        return ~(s[TAP_HI] ^ s[TAP_LO]);
    endfunction
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that overrides a coincident increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {CNT_W{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;
endmodule

// File: rtl/prbs7_checker.sv
// Self-synchronising PRBS7 checker: loads the received stream while searching,
// then free-runs its LFSR once locked and flags, counts and pulses mismatches.
module prbs7_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_CNT    = 16,
    parameter int UNLOCK_ERRS = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    input  logic             cnt_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] bit_count
);
    state_t               state_reg;
    logic [PRBS7_W-1:0]   lfsr_reg;
    logic [7:0]           match_cnt_reg;
    logic [3:0]           miss_cnt_reg;
    logic                 locked_reg;
    logic                 err_pulse_reg;

    logic                 pred;
    logic                 mismatch;
    logic                 locked_valid;
    logic [7:0]           match_cnt_next;
    logic [3:0]           miss_cnt_next;

    assign pred           = prbs7_fb(lfsr_reg);
    assign mismatch       = bit_in != pred;
    assign locked_valid   = bit_valid && (state_reg == LOCKED);
    assign match_cnt_next = match_cnt_reg + 8'd1;
    assign miss_cnt_next  = miss_cnt_reg + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= SEARCH;
            lfsr_reg      <= '0;
            match_cnt_reg <= '0;
            miss_cnt_reg  <= '0;
            locked_reg    <= 1'b0;
            err_pulse_reg <= 1'b0;
        end else begin
            err_pulse_reg <= locked_valid && mismatch;
            if (bit_valid) begin
                case (state_reg)
                    SEARCH: begin
                        lfsr_reg <= {lfsr_reg[PRBS7_W-2:0], bit_in};
                        // The all-ones state is the XNOR lock-up; a stuck-high line must never qualify.
                        if (lfsr_reg == LOCKUP_STATE || mismatch) begin
                            match_cnt_reg <= '0;
                        end else begin
                            match_cnt_reg <= match_cnt_next;
                            if (match_cnt_next == 8'(LOCK_CNT)) begin
                                state_reg    <= LOCKED;
                                locked_reg   <= 1'b1;
                                miss_cnt_reg <= '0;
                            end
                        end
                    end
                    LOCKED: begin
                        lfsr_reg <= {lfsr_reg[PRBS7_W-2:0], pred};
                        if (mismatch) begin
                            miss_cnt_reg <= miss_cnt_next;
                            if (miss_cnt_next == 4'(UNLOCK_ERRS)) begin
                                state_reg     <= SEARCH;
                                locked_reg    <= 1'b0;
                                match_cnt_reg <= '0;
                            end
                        end else begin
                            miss_cnt_reg <= '0;
                        end
                    end
                    default: state_reg <= SEARCH;
                endcase
            end
        end
    end

    // Index 0 counts mismatches, index 1 counts every checked bit.
    logic             cnt_inc [2];
    logic [CNT_W-1:0] cnt_val [2];

    assign cnt_inc[0] = locked_valid && mismatch;
    assign cnt_inc[1] = locked_valid;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            sat_counter #(
                .CNT_W(CNT_W)
            ) u_cnt (
                .clk   (clk),
                .rst   (rst),
                .inc   (cnt_inc[gi]),
                .clr   (cnt_clr),
                .count (cnt_val[gi])
            );
        end
    endgenerate

    assign locked    = locked_reg;
    assign err_pulse = err_pulse_reg;
    assign err_count = cnt_val[0];
    assign bit_count = cnt_val[1];
endmodule
